// File: rtl/pulse_symbol_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module      : pulse_symbol_sequencer_if
//  Description : Valid/ready symbol push port feeding the sequencer FIFO.
//  Revision    : 1.0 - initial release
// ============================================================================
interface pulse_symbol_sequencer_if #(
  parameter int DUR_WIDTH = 8
) ();

  logic                 sym_valid;
  logic                 sym_ready;
  logic                 sym_level;
  logic [DUR_WIDTH-1:0] sym_duration;
  logic                 sym_last;

  modport master (
    output sym_valid,
    output sym_level,
    output sym_duration,
    output sym_last,
    input  sym_ready
  );

  modport slave (
    input  sym_valid,
    input  sym_level,
    input  sym_duration,
    input  sym_last,
    output sym_ready
  );

endinterface
`default_nettype wire

// File: rtl/pulse_symbol_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : pulse_symbol_sequencer
//  Description : Plays buffered (level, duration) symbols on pulse_out after a
//                start rising edge, with optional carrier gating of high symbols.
//  Revision    : 1.0 - initial release
// ============================================================================
module pulse_symbol_sequencer #(
  parameter int DUR_WIDTH     = 8,
  parameter int FIFO_DEPTH    = 4,
  parameter int CARRIER_WIDTH = 8
) (
  input  wire logic                           clk,
  input  wire logic                           sys_rst_n,
  input  wire logic                           start_d1,
  input  wire logic                           start_d2,
  input  wire logic                           stop,
  pulse_symbol_sequencer_if.slave             sym,
  input  wire logic                           carrier_en,
  input  wire logic [CARRIER_WIDTH-1:0]       carrier_half_period,
  input  wire logic                           idle_level,
  output logic                                pulse_out,
  output logic                                busy,
  output logic                                done,
  output logic                                underflow,
  output logic [$clog2(FIFO_DEPTH):0]         fifo_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int EW = DUR_WIDTH + 2;
  localparam logic [AW:0] C_FULL = (AW+1)'(FIFO_DEPTH);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  logic [0:0]               state_q, state_d;
  logic [EW-1:0]            mem_q [FIFO_DEPTH];
  logic [AW-1:0]            wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]            rd_ptr_q, rd_ptr_d;
  logic [AW:0]              count_q, count_d;
  logic [DUR_WIDTH-1:0]     dur_cnt_q, dur_cnt_d;
  logic [CARRIER_WIDTH-1:0] car_cnt_q, car_cnt_d;
  logic                     phase_q, phase_d;
  logic                     level_q, level_d;
  logic                     last_q, last_d;
  logic                     pulse_q, pulse_d;
  logic                     done_q, done_d;
  logic                     underflow_q, underflow_d;

  logic                     start_edge;
  logic                     fifo_empty;
  logic                     push;
  logic                     pop;
  logic                     flush;
  logic [EW-1:0]            head;
  logic                     head_level;
  logic [DUR_WIDTH-1:0]     head_dur;
  logic                     head_last;
  logic                     car_wrap;
  logic                     phase_nx;
  logic [CARRIER_WIDTH-1:0] car_nx;

  assign start_edge    = start_d1 & ~start_d2;
  assign fifo_empty    = (count_q == '0);
  assign sym.sym_ready = (count_q != C_FULL);
  // stop discards any simultaneous push
  assign push          = sym.sym_valid & sym.sym_ready & ~stop;

  assign head       = mem_q[rd_ptr_q];
  assign head_level = head[EW-1];
  assign head_dur   = head[EW-2:1];
  assign head_last  = head[0];

  // Carrier runs free across symbol boundaries inside a frame
  assign car_wrap = (car_cnt_q == carrier_half_period);
  assign phase_nx = car_wrap ? ~phase_q : phase_q;
  assign car_nx   = car_wrap ? '0 : car_cnt_q + CARRIER_WIDTH'(1);

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {sym.sym_level, sym.sym_duration, sym.sym_last};
    end
  end

  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q     <= S_IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      dur_cnt_q   <= '0;
      car_cnt_q   <= '0;
      phase_q     <= 1'b0;
      level_q     <= 1'b0;
      last_q      <= 1'b0;
      pulse_q     <= 1'b0;
      done_q      <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      dur_cnt_q   <= dur_cnt_d;
      car_cnt_q   <= car_cnt_d;
      phase_q     <= phase_d;
      level_q     <= level_d;
      last_q      <= last_d;
      pulse_q     <= pulse_d;
      done_q      <= done_d;
      underflow_q <= underflow_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (stop) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: if (start_edge && !fifo_empty) state_d = S_RUN;
        S_RUN:  if (dur_cnt_q == '0 && (last_q || fifo_empty)) state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    pop         = 1'b0;
    flush       = 1'b0;
    dur_cnt_d   = dur_cnt_q;
    car_cnt_d   = car_cnt_q;
    phase_d     = phase_q;
    level_d     = level_q;
    last_d      = last_q;
    pulse_d     = pulse_q;
    done_d      = 1'b0;
    underflow_d = underflow_q;
    if (stop) begin
      flush   = 1'b1;
      pulse_d = idle_level;
    end else begin
      case (state_q)
        S_IDLE: begin
          pulse_d = idle_level;
          if (start_edge) begin
            if (!fifo_empty) begin
              pop         = 1'b1;
              underflow_d = 1'b0;
              dur_cnt_d   = head_dur;
              car_cnt_d   = '0;
              phase_d     = 1'b1;
              level_d     = head_level;
              last_d      = head_last;
              pulse_d     = head_level;
            end else begin
              underflow_d = 1'b1;
              done_d      = 1'b1;
            end
          end
        end
        S_RUN: begin
          car_cnt_d = car_nx;
          phase_d   = phase_nx;
          if (dur_cnt_q != '0) begin
            dur_cnt_d = dur_cnt_q - DUR_WIDTH'(1);
            pulse_d   = level_q & (~carrier_en | phase_nx);
          end else if (last_q) begin
            pulse_d = idle_level;
            done_d  = 1'b1;
          end else if (!fifo_empty) begin
            pop       = 1'b1;
            dur_cnt_d = head_dur;
            level_d   = head_level;
            last_d    = head_last;
            pulse_d   = head_level & (~carrier_en | phase_nx);
          end else begin
            underflow_d = 1'b1;
            done_d      = 1'b1;
            pulse_d     = idle_level;
          end
        end
        default: pulse_d = idle_level;
      endcase
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + (AW+1)'(1);
        2'b01:   count_d = count_q - (AW+1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  assign pulse_out  = pulse_q;
  assign busy       = (state_q == S_RUN);
  assign done       = done_q;
  assign underflow  = underflow_q;
  assign fifo_count = count_q;

endmodule
`default_nettype wire
